// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Brief    : RV32I conditional-branch resolver; registers the next PC and a
//            taken flag. Optional misaligned-target trap: BRANCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] register_source_1,
  input  logic [XLEN-1:0] register_source_2,
  input  logic [XLEN-1:0] program_counter,
  input  logic [XLEN-1:0] offset,
  input  logic [2:0]      opcode,
  input  logic            enable_n,
`ifdef BRANCH_MISALIGN_TRAP_EN
  output logic            misaligned,
`endif
  output logic [XLEN-1:0] new_program_counter,
  output logic            branch_taken
);

  localparam logic [XLEN-1:0] c_pc_step = XLEN'(PC_STEP);

  localparam logic [2:0] c_beq  = 3'b000;
  localparam logic [2:0] c_bne  = 3'b001;
  localparam logic [2:0] c_blt  = 3'b100;
  localparam logic [2:0] c_bge  = 3'b101;
  localparam logic [2:0] c_bltu = 3'b110;
  localparam logic [2:0] c_bgeu = 3'b111;

  logic            w_cond;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fall_through;
  logic [XLEN-1:0] r_npc;
  logic            r_taken;

  always_comb begin
    w_cond = 1'b0;
    case (opcode)
      c_beq:   w_cond = (register_source_1 == register_source_2);
      c_bne:   w_cond = (register_source_1 != register_source_2);
      c_blt:   w_cond = ($signed(register_source_1) <  $signed(register_source_2));
      c_bge:   w_cond = ($signed(register_source_1) >= $signed(register_source_2));
      c_bltu:  w_cond = (register_source_1 <  register_source_2);
      c_bgeu:  w_cond = (register_source_1 >= register_source_2);
      default: w_cond = 1'b0;
    endcase
  end

  // Both sums wrap modulo 2^XLEN; the carry is intentionally dropped.
  assign w_target       = program_counter + offset;
  assign w_fall_through = program_counter + c_pc_step;

`ifdef BRANCH_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misaligned;

  // A taken branch to a non-word-aligned target is suppressed and flagged.
  assign w_misalign = w_cond & (w_target[1:0] != 2'b00);
  assign w_taken    = w_cond & ~w_misalign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misaligned <= 1'b0;
    end else if (!enable_n) begin
      r_misaligned <= w_misalign;
    end
  end

  assign misaligned = r_misaligned;
`else
  assign w_taken = w_cond;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_npc   <= '0;
      r_taken <= 1'b0;
    end else if (!enable_n) begin
      r_npc   <= w_taken ? w_target : w_fall_through;
      r_taken <= w_taken;
    end
  end

  assign new_program_counter = r_npc;
  assign branch_taken        = r_taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_unit
// Brief    : Directed self-checking bench for branch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic [31:0] off;
  logic [2:0]  op;
  logic        en_n;
  logic [31:0] npc;
  logic        taken;
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int passes;
  int total;

  branch_unit #(.XLEN(32), .PC_STEP(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .register_source_1   (rs1),
    .register_source_2   (rs2),
    .program_counter     (pc),
    .offset              (off),
    .opcode              (op),
    .enable_n            (en_n),
`ifdef BRANCH_MISALIGN_TRAP_EN
    .misaligned          (misaligned),
`endif
    .new_program_counter (npc),
    .branch_taken        (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] o, input logic [2:0] f, input logic e);
    @(posedge clk);
    #1;
    rs1 = a; rs2 = b; pc = p; off = o; op = f; en_n = e;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] e_npc, input logic e_taken);
    check({tag, "_npc"}, npc, e_npc);
    check({tag, "_taken"}, {31'b0, taken}, {31'b0, e_taken});
  endtask

  initial begin
    passes = 0;
    total  = 0;
    reset  = 1'b1;
    rs1 = 32'hDEADBEEF; rs2 = 32'h0; pc = 32'h4000; off = 32'h40; op = 3'b001; en_n = 1'b0;

    // Reset held across edges
    settle();
    expect_out("reset_held", 32'h0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    drive(32'h12345678, 32'h12345678, 32'h00001000, 32'h00000010, 3'b000, 1'b0);
    settle(); expect_out("beq_taken", 32'h00001010, 1'b1);
    drive(32'h12345678, 32'h12345678, 32'h00001000, 32'h00000010, 3'b001, 1'b0);
    settle(); expect_out("bne_not", 32'h00001004, 1'b0);

    drive(32'hFFFFFFFF, 32'h00000001, 32'h00002000, 32'hFFFFFFF8, 3'b100, 1'b0);
    settle(); expect_out("blt", 32'h00001FF8, 1'b1);
    drive(32'hFFFFFFFF, 32'h00000001, 32'h00002000, 32'hFFFFFFF8, 3'b110, 1'b0);
    settle(); expect_out("bltu", 32'h00002004, 1'b0);
    drive(32'hFFFFFFFF, 32'h00000001, 32'h00002000, 32'hFFFFFFF8, 3'b111, 1'b0);
    settle(); expect_out("bgeu", 32'h00001FF8, 1'b1);
    drive(32'hFFFFFFFF, 32'h00000001, 32'h00002000, 32'hFFFFFFF8, 3'b101, 1'b0);
    settle(); expect_out("bge", 32'h00002004, 1'b0);

    // Hold with enable_n high while everything else changes
    drive(32'h00000005, 32'h00000005, 32'h00003000, 32'h00000100, 3'b000, 1'b0);
    settle(); expect_out("pre_hold", 32'h00003100, 1'b1);
    drive(32'h00000001, 32'h00000002, 32'h00009000, 32'h00000008, 3'b001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      expect_out($sformatf("hold%0d", i), 32'h00003100, 1'b1);
    end

    // Reserved opcodes with equal operands must still fall through
    drive(32'h00000007, 32'h00000007, 32'h00000100, 32'h00000040, 3'b010, 1'b0);
    settle(); expect_out("rsvd010", 32'h00000104, 1'b0);
    drive(32'h00000007, 32'h00000007, 32'h00000100, 32'h00000040, 3'b011, 1'b0);
    settle(); expect_out("rsvd011", 32'h00000104, 1'b0);

    drive(32'h00000003, 32'h00000003, 32'hFFFFFFFC, 32'h00000040, 3'b001, 1'b0);
    settle(); expect_out("wrap_fall", 32'h00000000, 1'b0);
    drive(32'h00000003, 32'h00000003, 32'hFFFFFFF0, 32'h00000020, 3'b000, 1'b0);
    settle(); expect_out("wrap_target", 32'h00000010, 1'b1);

    drive(32'h0000000A, 32'h0000000A, 32'h00001000, 32'h00000002, 3'b000, 1'b0);
    settle();
`ifdef BRANCH_MISALIGN_TRAP_EN
    expect_out("misalign", 32'h00001004, 1'b0);
    check("misalign_flag", {31'b0, misaligned}, 32'h1);
    drive(32'h0000000A, 32'h0000000A, 32'h00001000, 32'h00000004, 3'b000, 1'b0);
    settle();
    expect_out("aligned", 32'h00001004, 1'b1);
    check("aligned_flag", {31'b0, misaligned}, 32'h0);
`else
    expect_out("odd_target", 32'h00001002, 1'b1);
`endif

    // Asynchronous reset mid-operation, between edges
    #2 reset = 1'b1;
    #1 expect_out("reset_async", 32'h0, 1'b0);
    settle(); expect_out("reset_hold", 32'h0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    rs1 = 32'h80000000; rs2 = 32'h00000001; pc = 32'h00000800; off = 32'h00000020;
    op = 3'b100; en_n = 1'b0;
    settle(); expect_out("post_reset", 32'h00000820, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
